// File: rtl/seed_stream_bridge_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seed_stream_bridge_pkg - block width and bridge FSM state encoding
// Rev 1.0
// ---------------------------------------------------------------------------
package seed_stream_bridge_pkg;

  localparam int BLOCK_W = 128;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LDKEY  = 3'd1,
    ST_LDDATA = 3'd2,
    ST_START  = 3'd3,
    ST_KEY    = 3'd4,
    ST_WAIT   = 3'd5,
    ST_UNLOAD = 3'd6
  } state_e;

endpackage
`default_nettype wire

// File: rtl/seed_word_shifter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seed_word_shifter - 128-bit register, parallel load, shift by WORD_W
// Rev 1.0
// ---------------------------------------------------------------------------
module seed_word_shifter
  import seed_stream_bridge_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load_i,
  input  logic [BLOCK_W-1:0] load_data_i,
  input  logic               shift_i,
  input  logic [WORD_W-1:0]  word_i,
  output logic [BLOCK_W-1:0] data_o,
  output logic [WORD_W-1:0]  word_o
);

  logic [BLOCK_W-1:0] data_q;
  logic [BLOCK_W-1:0] shifted;

  // New words enter at the LSW end so the first word ends up most significant.
  generate
    if (WORD_W == BLOCK_W) begin : g_full_word
      assign shifted = word_i;
    end else begin : g_part_word
      assign shifted = {data_q[BLOCK_W-WORD_W-1:0], word_i};
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q <= '0;
    end else if (load_i) begin
      data_q <= load_data_i;
    end else if (shift_i) begin
      data_q <= shifted;
    end
  end

  assign data_o = data_q;
  assign word_o = data_q[BLOCK_W-1 -: WORD_W];

endmodule
`default_nettype wire

// File: rtl/seed_stream_bridge.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seed_stream_bridge - word-serial load/unload front end for the SEED128 core
// Rev 1.0
// ---------------------------------------------------------------------------
module seed_stream_bridge
  import seed_stream_bridge_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic               i_Clk,
  input  logic               i_Rst,
  input  logic               i_fStart,
  input  logic               i_fDec,
  input  logic               i_fNewKey,
  input  logic [WORD_W-1:0]  i_Word,
  input  logic               i_fValid,
  output logic               o_fReady,
  output logic [WORD_W-1:0]  o_Word,
  output logic               o_fValid,
  input  logic               i_fReady,
  output logic [BLOCK_W-1:0] o_Core_Text,
  output logic               o_Core_fStart,
  output logic               o_Core_fDec,
  input  logic [BLOCK_W-1:0] i_Core_Text,
  input  logic               i_Core_fDone,
  output logic               o_fBusy
);

  localparam int            NW   = BLOCK_W / WORD_W;
  localparam int            CW   = $clog2(NW) + 1;
  localparam logic [CW-1:0] LAST = CW'(NW - 1);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q;
  logic               dec_q;
  logic               ready_q, valid_q, busy_q, core_start_q, core_dec_q;
  logic               in_beat, out_beat, last_cnt;
  logic [BLOCK_W-1:0] key_data, text_data, result_data;
  logic [WORD_W-1:0]  key_word, text_word, result_word;
  logic               unused_bits;

  assign in_beat  = i_fValid & ready_q;
  assign out_beat = valid_q & i_fReady;
  assign last_cnt = (cnt_q == LAST);

  seed_word_shifter #(.WORD_W(WORD_W)) u_key (
    .clk_i       (i_Clk),
    .rst_i       (i_Rst),
    .load_i      (1'b0),
    .load_data_i ('0),
    .shift_i     ((state_q == ST_LDKEY) && in_beat),
    .word_i      (i_Word),
    .data_o      (key_data),
    .word_o      (key_word)
  );

  seed_word_shifter #(.WORD_W(WORD_W)) u_text (
    .clk_i       (i_Clk),
    .rst_i       (i_Rst),
    .load_i      (1'b0),
    .load_data_i ('0),
    .shift_i     ((state_q == ST_LDDATA) && in_beat),
    .word_i      (i_Word),
    .data_o      (text_data),
    .word_o      (text_word)
  );

  seed_word_shifter #(.WORD_W(WORD_W)) u_result (
    .clk_i       (i_Clk),
    .rst_i       (i_Rst),
    .load_i      ((state_q == ST_WAIT) && i_Core_fDone),
    .load_data_i (i_Core_Text),
    .shift_i     ((state_q == ST_UNLOAD) && out_beat),
    .word_i      ('0),
    .data_o      (result_data),
    .word_o      (result_word)
  );

  assign unused_bits = ^{key_word, text_word, result_data};

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (i_fStart) state_d = i_fNewKey ? ST_LDKEY : ST_LDDATA;
      ST_LDKEY:  if (in_beat && last_cnt) state_d = ST_LDDATA;
      ST_LDDATA: if (in_beat && last_cnt) state_d = ST_START;
      ST_START:  state_d = ST_KEY;
      ST_KEY:    state_d = ST_WAIT;
      ST_WAIT:   if (i_Core_fDone) state_d = ST_UNLOAD;
      ST_UNLOAD: if (out_beat && last_cnt) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output flags are registered from the next state so they align with state_q.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      dec_q        <= 1'b0;
      ready_q      <= 1'b0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      core_start_q <= 1'b0;
      core_dec_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q) begin
        cnt_q <= '0;
      end else if (in_beat || out_beat) begin
        cnt_q <= cnt_q + CW'(1);
      end
      if ((state_q == ST_IDLE) && i_fStart) begin
        dec_q <= i_fDec;
      end
      ready_q      <= (state_d == ST_LDKEY) || (state_d == ST_LDDATA);
      valid_q      <= (state_d == ST_UNLOAD);
      busy_q       <= (state_d != ST_IDLE);
      core_start_q <= (state_d == ST_START);
      core_dec_q   <= ((state_d == ST_START) || (state_d == ST_KEY) ||
                       (state_d == ST_WAIT)) ? dec_q : 1'b0;
    end
  end

  always_comb begin
    o_Core_Text = '0;
    case (state_q)
      ST_START:        o_Core_Text = text_data;
      ST_KEY, ST_WAIT: o_Core_Text = key_data;
      default:         o_Core_Text = '0;
    endcase
  end

  assign o_fReady      = ready_q;
  assign o_fValid      = valid_q;
  assign o_fBusy       = busy_q;
  assign o_Core_fStart = core_start_q;
  assign o_Core_fDec   = core_dec_q;
  assign o_Word        = result_word;

endmodule
`default_nettype wire

// File: tb/tb_seed_stream_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// tb_seed_stream_bridge - bench for the 32-bit and 8-bit bridge builds
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_seed_stream_bridge;

  localparam logic [127:0] PT        = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] CT        = 128'h5EBAC6E0054E166819AFF1CC6D346CDB;
  localparam logic [127:0] SPUR_TEXT = 128'hDEADBEEF_CAFEF00D_0BADC0DE_12345678;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Stand-in for the core: the SEED known-answer pair, otherwise an invertible mix.
  function automatic logic [127:0] core_fn(input logic [127:0] t, input logic [127:0] k,
                                           input logic d);
    logic [127:0] x;
    if (k == '0 && !d && t == PT) return CT;
    if (k == '0 && d && t == CT) return PT;
    if (!d) return {t[119:0], t[127:120]} ^ k;
    x = t ^ k;
    return {x[7:0], x[127:8]};
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got no event required event within budget", nm);
  endtask

  // 32-bit instance
  logic         st32 = 0, dc32 = 0, nk32 = 0, iv32 = 0, dr32 = 1, spur32 = 0;
  logic [31:0]  iw32 = '0;
  logic         rdy32, ov32, cs32, cd32, busy32, cdone32;
  logic [31:0]  ow32;
  logic [127:0] ct32, cit32;

  // 8-bit instance
  logic         st8 = 0, dc8 = 0, nk8 = 0, iv8 = 0, dr8 = 1;
  logic [7:0]   iw8 = '0;
  logic         rdy8, ov8, cs8, cd8, busy8;
  logic [7:0]   ow8;
  logic [127:0] ct8;

  // core models
  logic         c32_pend, c32_run, c32_done, c32_dec;
  logic [127:0] c32_text, c32_key, c32_out;
  int           c32_cnt;
  logic         c8_pend, c8_run, c8_done, c8_dec;
  logic [127:0] c8_text, c8_key, c8_out;
  int           c8_cnt;

  assign cdone32 = c32_done | spur32;
  assign cit32   = spur32 ? SPUR_TEXT : c32_out;

  seed_stream_bridge #(.WORD_W(32)) u_dut32 (
    .i_Clk(clk), .i_Rst(rst), .i_fStart(st32), .i_fDec(dc32), .i_fNewKey(nk32),
    .i_Word(iw32), .i_fValid(iv32), .o_fReady(rdy32), .o_Word(ow32), .o_fValid(ov32),
    .i_fReady(dr32), .o_Core_Text(ct32), .o_Core_fStart(cs32), .o_Core_fDec(cd32),
    .i_Core_Text(cit32), .i_Core_fDone(cdone32), .o_fBusy(busy32)
  );

  seed_stream_bridge #(.WORD_W(8)) u_dut8 (
    .i_Clk(clk), .i_Rst(rst), .i_fStart(st8), .i_fDec(dc8), .i_fNewKey(nk8),
    .i_Word(iw8), .i_fValid(iv8), .o_fReady(rdy8), .o_Word(ow8), .o_fValid(ov8),
    .i_fReady(dr8), .o_Core_Text(ct8), .o_Core_fStart(cs8), .o_Core_fDec(cd8),
    .i_Core_Text(c8_out), .i_Core_fDone(c8_done), .o_fBusy(busy8)
  );

  always @(posedge clk) begin
    if (rst) begin
      c32_pend <= 0; c32_run <= 0; c32_done <= 0; c32_cnt <= 0; c32_out <= '0;
    end else begin
      c32_done <= 0;
      if (cs32) begin
        c32_text <= ct32; c32_dec <= cd32; c32_pend <= 1;
      end else if (c32_pend) begin
        c32_key <= ct32; c32_pend <= 0; c32_run <= 1; c32_cnt <= 15;
      end else if (c32_run) begin
        if (c32_cnt == 0) begin
          c32_run <= 0; c32_done <= 1; c32_out <= core_fn(c32_text, c32_key, c32_dec);
        end else c32_cnt <= c32_cnt - 1;
      end
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      c8_pend <= 0; c8_run <= 0; c8_done <= 0; c8_cnt <= 0; c8_out <= '0;
    end else begin
      c8_done <= 0;
      if (cs8) begin
        c8_text <= ct8; c8_dec <= cd8; c8_pend <= 1;
      end else if (c8_pend) begin
        c8_key <= ct8; c8_pend <= 0; c8_run <= 1; c8_cnt <= 15;
      end else if (c8_run) begin
        if (c8_cnt == 0) begin
          c8_run <= 0; c8_done <= 1; c8_out <= core_fn(c8_text, c8_key, c8_dec);
        end else c8_cnt <= c8_cnt - 1;
      end
    end
  end

  // reference model state for the 32-bit instance
  logic [127:0] key_m = '0, exp_text = '0, exp_key = '0;
  logic         exp_dec = 0;
  logic [31:0]  exp32[$];
  logic [31:0]  got32[$];
  int           beats32 = 0;
  bit           seen_start = 0;

  initial begin : p_cmp32
    logic        prev_stall, prev_done, prev_start;
    logic [31:0] hold_w, w;
    prev_stall = 0; prev_done = 0; prev_start = 0; hold_w = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 0; prev_done = 0; prev_start = 0;
      end else begin
        if (prev_stall) chk("stall_hold", {ov32, ow32}, {1'b1, hold_w});
        if (ov32 && dr32) begin
          if (exp32.size() == 0) fail("unexpected_word");
          else begin
            w = exp32.pop_front();
            chk("out_word", ow32, w);
          end
          got32.push_back(ow32);
          beats32++;
        end
        if (prev_done) chk("done_to_valid", ov32, 1'b1);
        if (prev_start) chk("key_after_start", {cs32, cd32, ct32}, {1'b0, exp_dec, exp_key});
        if (cs32) begin
          chk("start_text", {cd32, ct32}, {exp_dec, exp_text});
          seen_start = 1;
        end
        if (!busy32 || rdy32 || ov32) chk("core_idle_zero", {cs32, cd32, ct32}, '0);
        prev_stall = ov32 && !dr32;
        hold_w     = ow32;
        prev_done  = c32_done;
        prev_start = cs32;
      end
    end
  end

  task automatic wait_idle32();
    int budget = 400;
    while (busy32 && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    if (busy32) fail("idle32_timeout");
  endtask

  task automatic start32(input bit nk, input bit dec);
    wait_idle32();
    st32 = 1; nk32 = nk; dc32 = dec;
    @(posedge clk); #1;
    st32 = 0; nk32 = 1'($urandom()); dc32 = 1'($urandom());
  endtask

  task automatic feed32(input logic [127:0] blk, input int gap, input bit spur, input int n);
    int idx = 0;
    int budget = 400;
    bit beat, spurred = 0;
    while (idx < n && budget > 0) begin
      iv32 = ($urandom_range(99) >= gap);
      iw32 = iv32 ? blk[127-32*idx -: 32] : $urandom();
      if (spur && idx == 1 && !spurred) begin
        spur32 = 1; spurred = 1;
      end
      beat = iv32 && rdy32;
      @(posedge clk); #1;
      spur32 = 0;
      if (beat) idx++;
      budget--;
    end
    iv32 = 0;
    if (idx < n) fail("feed32_timeout");
  endtask

  task automatic send32(input bit nk, input bit dec, input logic [127:0] key,
                        input logic [127:0] txt, input int gap, input bit spur);
    logic [127:0] r;
    if (nk) key_m = key;
    exp_text = txt; exp_key = key_m; exp_dec = dec;
    start32(nk, dec);
    if (nk) feed32(key, gap, 0, 4);
    feed32(txt, gap, spur, 4);
    r = core_fn(txt, key_m, dec);
    for (int i = 0; i < 4; i++) exp32.push_back(r[127-32*i -: 32]);
  endtask

  task automatic drain32(input int stall_at);
    int budget = 400;
    int base = beats32;
    bit stalled = 0;
    while ((exp32.size() != 0 || busy32) && budget > 0) begin
      if (stall_at >= 0 && !stalled && ov32 && (beats32 - base) == stall_at) begin
        dr32 = 0;
        repeat (5) @(posedge clk);
        #1;
        dr32 = 1; stalled = 1;
      end else begin
        @(posedge clk); #1;
      end
      budget--;
    end
    if (budget == 0) fail("drain32_timeout");
  endtask

  task automatic feed8(input logic [127:0] blk);
    int idx = 0;
    int budget = 400;
    bit beat;
    while (idx < 16 && budget > 0) begin
      iv8 = 1; iw8 = blk[127-8*idx -: 8];
      beat = rdy8;
      @(posedge clk); #1;
      if (beat) idx++;
      budget--;
    end
    iv8 = 0;
    if (idx < 16) fail("feed8_timeout");
  endtask

  initial begin : p_main
    logic [127:0] k, t, r8;
    int           n8, budget;

    rst = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_ready", rdy32, 0);
    chk("rst_valid", ov32, 0);
    chk("rst_busy", busy32, 0);
    chk("rst_core_start", cs32, 0);
    chk("rst_core_dec", cd32, 0);
    chk("rst_core_text", ct32, 0);
    chk("rst_word", ow32, 0);
    chk("rst_busy8", {busy8, ov8, rdy8}, 0);
    @(posedge clk); #1;

    // known-answer encrypt, new all-zero key
    got32.delete();
    send32(1, 0, '0, PT, 0, 0);
    drain32(-1);
    chk("kat_enc_count", got32.size(), 4);
    chk("kat_enc_w0", got32[0], 32'h5EBAC6E0);
    chk("kat_enc_w1", got32[1], 32'h054E1668);
    chk("kat_enc_w2", got32[2], 32'h19AFF1CC);
    chk("kat_enc_w3", got32[3], 32'h6D346CDB);

    // decrypt reusing the retained key
    got32.delete();
    send32(0, 1, '0, CT, 0, 0);
    drain32(-1);
    chk("kat_dec_count", got32.size(), 4);
    chk("kat_dec_w0", got32[0], 32'h00010203);
    chk("kat_dec_w1", got32[1], 32'h04050607);
    chk("kat_dec_w2", got32[2], 32'h08090A0B);
    chk("kat_dec_w3", got32[3], 32'h0C0D0E0F);

    // input gaps and a 5-cycle output stall
    k = rand128(); t = rand128();
    send32(1, 0, k, t, 40, 0);
    drain32(2);

    // spurious core done while loading data
    send32(0, 1, '0, rand128(), 20, 1);
    drain32(-1);

    // start pulse while waiting on the core
    seen_start = 0;
    send32(0, 0, '0, rand128(), 0, 0);
    budget = 50;
    while (!seen_start && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    if (!seen_start) fail("start_seen_timeout");
    repeat (3) @(posedge clk);
    #1;
    st32 = 1; nk32 = 1;
    @(posedge clk); #1;
    st32 = 0; nk32 = 0;
    drain32(-1);
    repeat (3) @(posedge clk);
    #1;
    chk("start_in_wait_ignored", {busy32, rdy32}, 0);

    // reset in the middle of a data load
    start32(0, 0);
    feed32(rand128(), 0, 0, 2);
    chk("in_lddata", rdy32, 1);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("rst_mid_busy", busy32, 0);
    chk("rst_mid_ready", rdy32, 0);
    key_m = '0;
    send32(0, 0, '0, rand128(), 10, 0);
    drain32(-1);

    // randomized blocks
    for (int b = 0; b < 8; b++) begin
      send32(1'($urandom()), 1'($urandom()), rand128(), rand128(),
             $urandom_range(0, 60), 1'($urandom()));
      drain32($urandom_range(0, 4));
    end

    // 8-bit build: 16-beat load and unload of the known-answer vectors
    st8 = 1; nk8 = 1; dc8 = 0;
    @(posedge clk); #1;
    st8 = 0; nk8 = 0;
    feed8('0);
    feed8(PT);
    r8 = '0; n8 = 0; budget = 200;
    while (n8 < 16 && budget > 0) begin
      @(negedge clk);
      if (ov8 && dr8) begin
        r8 = {r8[119:0], ow8};
        n8++;
      end
      budget--;
    end
    chk("w8_count", n8, 16);
    chk("w8_first_byte", r8[127:120], 8'h5E);
    chk("w8_ct", r8, CT);
    @(posedge clk); #1;
    chk("w8_idle", busy8, 0);

    repeat (3) @(posedge clk);
    chk("exp_queue_empty", exp32.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin : p_watchdog
    #2000000;
    n_errors++;
    $display("FAIL watchdog: got timeout required completion");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1);
  end

endmodule
`default_nettype wire
